// File: rtl/eth_rx_frame_sched_pkg.sv
// Shared types and constants for the receive-side frame scheduler.
package eth_rx_frame_sched_pkg;

  localparam int unsigned C_LEN_W = 11;
  localparam int unsigned C_CLS_W = 2;
  localparam logic [C_CLS_W-1:0] CLS_DROP = '0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFwd,
    StFlush,
    StDrain
  } state_e;

  // A frame is discarded on bad CRC, drop/unknown class or oversize length.
  function automatic logic frame_drop(input logic               crc_ok,
                                      input logic [C_CLS_W-1:0] cls,
                                      input logic [C_LEN_W-1:0] len,
                                      input int unsigned        num_dest,
                                      input int unsigned        max_len);
    return !crc_ok || (cls == CLS_DROP) || (32'(cls) > num_dest) || (32'(len) > max_len);
  endfunction

endpackage

// File: rtl/eth_rx_out_reg.sv
// One-entry valid/ready output register carrying a byte and an end-of-frame flag.
module eth_rx_out_reg #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DataW-1:0] in_data_i,
  input  logic             in_last_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  output logic [DataW-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_vld_o,
  input  logic             out_rdy_i
);

  logic [DataW-1:0] data_q;
  logic             last_q;
  logic             vld_q;

  assign in_rdy_o   = !vld_q || out_rdy_i;
  assign out_data_o = data_q;
  assign out_last_o = last_q;
  assign out_vld_o  = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      data_q <= in_data_i;
      last_q <= in_last_i;
      vld_q  <= 1'b1;
    end else if (out_rdy_i) begin
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_frame_sched.sv
// Pops one control entry per frame, then forwards or flushes that many data bytes.
module eth_rx_frame_sched
  import eth_rx_frame_sched_pkg::*;
#(
  parameter int unsigned P_NUM_DEST = 2,
  parameter int unsigned P_MAX_LEN  = 1522,
  parameter int unsigned P_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [C_LEN_W-1:0]    ctrl_len_i,
  input  logic                  ctrl_crc_ok_i,
  input  logic [C_CLS_W-1:0]    ctrl_class_i,
  input  logic                  ctrl_vld_i,
  output logic                  ctrl_rdy_o,
  input  logic [7:0]            data_in_i,
  input  logic                  data_in_vld_i,
  output logic                  data_in_rdy_o,
  output logic [7:0]            out_data_o,
  output logic                  out_last_o,
  output logic [P_NUM_DEST-1:0] out_vld_o,
  input  logic [P_NUM_DEST-1:0] out_rdy_i,
  output logic [P_CNT_W-1:0]    frm_cnt_o,
  output logic [P_CNT_W-1:0]    drop_cnt_o
);

  localparam int unsigned SelW = (P_NUM_DEST > 1) ? $clog2(P_NUM_DEST) : 1;

  state_e             state_q;
  logic [C_LEN_W-1:0] rem_q;
  logic [SelW-1:0]    sel_q;
  logic               ctrl_rdy_q;
  logic [P_CNT_W-1:0] frm_cnt_q;
  logic [P_CNT_W-1:0] drop_cnt_q;

  logic sel_rdy;
  logic reg_in_vld;
  logic reg_in_rdy;
  logic reg_out_vld;
  logic rem_last;
  logic data_acc;

  always_comb begin
    sel_rdy       = out_rdy_i[sel_q];
    rem_last      = (rem_q == C_LEN_W'(1));
    reg_in_vld    = (state_q == StFwd) && data_in_vld_i;
    data_in_rdy_o = (state_q == StFwd) ? reg_in_rdy : (state_q == StFlush);
    data_acc      = data_in_vld_i && data_in_rdy_o;
    out_vld_o     = '0;
    if (reg_out_vld) out_vld_o[sel_q] = 1'b1;
  end

  assign ctrl_rdy_o = ctrl_rdy_q;
  assign frm_cnt_o  = frm_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

  eth_rx_out_reg #(
    .DataW(8)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data_i (data_in_i),
    .in_last_i (rem_last),
    .in_vld_i  (reg_in_vld),
    .in_rdy_o  (reg_in_rdy),
    .out_data_o(out_data_o),
    .out_last_o(out_last_o),
    .out_vld_o (reg_out_vld),
    .out_rdy_i (sel_rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      sel_q      <= '0;
      ctrl_rdy_q <= 1'b0;
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_vld_i) begin
            ctrl_rdy_q <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          ctrl_rdy_q <= 1'b0;
          rem_q      <= ctrl_len_i;
          sel_q      <= SelW'(ctrl_class_i - 1'b1);
          if (ctrl_len_i == '0) begin
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            state_q <= StIdle;
          end else if (frame_drop(ctrl_crc_ok_i, ctrl_class_i, ctrl_len_i, P_NUM_DEST,
                                  P_MAX_LEN)) begin
            state_q <= StFlush;
          end else begin
            state_q <= StFwd;
          end
        end
        StFlush: begin
          if (data_acc) begin
            rem_q <= rem_q - 1'b1;
            if (rem_last) begin
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StFwd: begin
          if (data_acc) begin
            rem_q <= rem_q - 1'b1;
            if (rem_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (reg_out_vld && sel_rdy) begin
            if (frm_cnt_q != '1) frm_cnt_q <= frm_cnt_q + 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_sched.sv
// Directed bench for eth_rx_frame_sched with a byte-counter data FIFO model.
module tb_eth_rx_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ctrl_len = '0;
  logic        ctrl_crc_ok = 1'b0;
  logic [1:0]  ctrl_class = '0;
  logic        ctrl_vld = 1'b0;
  logic        ctrl_rdy;
  logic [7:0]  data_in = '0;
  logic        data_in_vld = 1'b1;
  logic        data_in_rdy;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_vld;
  logic [1:0]  out_rdy = 2'b11;
  logic [15:0] frm_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  eth_rx_frame_sched #(
    .P_NUM_DEST(2),
    .P_MAX_LEN (1522),
    .P_CNT_W   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_len_i   (ctrl_len),
    .ctrl_crc_ok_i(ctrl_crc_ok),
    .ctrl_class_i (ctrl_class),
    .ctrl_vld_i   (ctrl_vld),
    .ctrl_rdy_o   (ctrl_rdy),
    .data_in_i    (data_in),
    .data_in_vld_i(data_in_vld),
    .data_in_rdy_o(data_in_rdy),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_vld_o    (out_vld),
    .out_rdy_i    (out_rdy),
    .frm_cnt_o    (frm_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int src_pos = 0;
  int ctrl_pops = 0;
  int pop_cyc = 0;
  int first_out_cyc = -1;
  int stall_at = -1;
  int stall_left = 0;
  int hold_viol = 0;
  int onehot_viol = 0;
  bit rdy_toggle = 1'b0;
  bit hold_pending = 1'b0;
  logic [7:0] hold_data;
  logic [1:0] hold_vld;
  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_dest[$];

  // Observe handshakes at negedge, then update the source models after the next posedge.
  task automatic step();
    bit popped;
    popped = 1'b0;
    @(negedge clk);
    cyc++;
    if (ctrl_vld && ctrl_rdy) begin
      ctrl_pops++;
      pop_cyc = cyc;
      popped  = 1'b1;
    end
    if (data_in_vld && data_in_rdy) src_pos++;
    for (int k = 0; k < 2; k++) begin
      if (out_vld[k] && out_rdy[k]) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_dest.push_back(k);
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end
    end
    if ($countones(out_vld) > 1) onehot_viol++;
    if (hold_pending && (out_data !== hold_data || out_vld !== hold_vld)) hold_viol++;
    hold_pending = |(out_vld & ~out_rdy);
    hold_data    = out_data;
    hold_vld     = out_vld;
    @(posedge clk);
    #1;
    if (popped) ctrl_vld = 1'b0;
    data_in = 8'(src_pos);
    if (stall_left > 0 && src_pos == stall_at) begin
      data_in_vld = 1'b0;
      stall_left--;
    end else begin
      data_in_vld = 1'b1;
    end
    out_rdy = rdy_toggle ? {1'b1, 1'(cyc % 2)} : 2'b11;
  endtask

  task automatic run_frame(input int len, input bit crc, input logic [1:0] cls,
                           input int exp_out, output bit ok);
    int s0;
    int o0;
    s0 = src_pos;
    o0 = got_data.size();
    first_out_cyc = -1;
    ok = 1'b0;
    ctrl_len    = 11'(len);
    ctrl_crc_ok = crc;
    ctrl_class  = cls;
    ctrl_vld    = 1'b1;
    for (int i = 0; i < 3 * len + 40; i++) begin
      step();
      if (!ctrl_vld && (src_pos - s0 == len) && (got_data.size() - o0 == exp_out) &&
          out_vld == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Mismatches of captured bytes against the counting source, destination and last flag.
  function automatic int count_bad(input int o0, input int s0, input int n, input int dest);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (o0 + i >= got_data.size()) bad++;
      else if (got_data[o0+i] !== 8'(s0 + i) || got_dest[o0+i] != dest ||
               got_last[o0+i] !== (i == n - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_vld !== 2'b00) begin n_errors++;
      $display("FAIL rst_out_vld: got %b want 00", out_vld); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++;
      $display("FAIL rst_out_data: got %h want 00", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_errors++;
      $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_checks++; if (ctrl_rdy !== 1'b0 || data_in_rdy !== 1'b0) begin n_errors++;
      $display("FAIL rst_rdy: got ctrl %b data %b want 0 0", ctrl_rdy, data_in_rdy); end
    n_checks++; if (frm_cnt !== 16'd0 || drop_cnt !== 16'd0) begin n_errors++;
      $display("FAIL rst_cnt: got frm %0d drop %0d want 0 0", frm_cnt, drop_cnt); end
    rst_n = 1'b1;
    step();
    n_checks++; if (ctrl_rdy !== 1'b0 || data_in_rdy !== 1'b0) begin n_errors++;
      $display("FAIL idle_rdy: got ctrl %b data %b want 0 0", ctrl_rdy, data_in_rdy); end
  endtask

  task automatic test_single_fwd();
    int s0, o0, bad;
    bit ok;
    s0 = src_pos;
    o0 = got_data.size();
    run_frame(64, 1'b1, 2'd1, 64, ok);
    n_checks++; if (!ok) begin n_errors++;
      $display("FAIL fwd64_done: got timeout want completion"); end
    bad = count_bad(o0, s0, 64, 0);
    n_checks++; if (bad != 0) begin n_errors++;
      $display("FAIL fwd64_bytes: got %0d bad bytes want 0", bad); end
    n_checks++; if (first_out_cyc != pop_cyc + 2) begin n_errors++;
      $display("FAIL fwd64_latency: got cycle %0d want %0d", first_out_cyc, pop_cyc + 2); end
    n_checks++; if (frm_cnt !== 16'd1 || drop_cnt !== 16'd0) begin n_errors++;
      $display("FAIL fwd64_cnt: got frm %0d drop %0d want 1 0", frm_cnt, drop_cnt); end
  endtask

  task automatic test_crc_drop_then_dest2();
    int s0, o0, bad;
    bit ok;
    s0 = src_pos;
    o0 = got_data.size();
    run_frame(60, 1'b0, 2'd1, 0, ok);
    n_checks++; if (!ok || src_pos - s0 != 60) begin n_errors++;
      $display("FAIL crc_flush: got %0d popped want 60", src_pos - s0); end
    n_checks++; if (got_data.size() != o0) begin n_errors++;
      $display("FAIL crc_no_out: got %0d bytes out want 0", got_data.size() - o0); end
    n_checks++; if (drop_cnt !== 16'd1 || frm_cnt !== 16'd1) begin n_errors++;
      $display("FAIL crc_cnt: got frm %0d drop %0d want 1 1", frm_cnt, drop_cnt); end
    s0 = src_pos;
    o0 = got_data.size();
    run_frame(42, 1'b1, 2'd2, 42, ok);
    bad = count_bad(o0, s0, 42, 1);
    n_checks++; if (!ok || bad != 0) begin n_errors++;
      $display("FAIL dest2_bytes: got ok %0d bad %0d want ok 1 bad 0", ok, bad); end
    n_checks++; if (frm_cnt !== 16'd2) begin n_errors++;
      $display("FAIL dest2_cnt: got frm %0d want 2", frm_cnt); end
  endtask

  task automatic test_backpressure();
    int s0, o0, bad;
    bit ok;
    s0 = src_pos;
    o0 = got_data.size();
    hold_viol = 0;
    rdy_toggle = 1'b1;
    run_frame(10, 1'b1, 2'd1, 10, ok);
    rdy_toggle = 1'b0;
    bad = count_bad(o0, s0, 10, 0);
    n_checks++; if (!ok || bad != 0) begin n_errors++;
      $display("FAIL bp_bytes: got ok %0d bad %0d want ok 1 bad 0", ok, bad); end
    n_checks++; if (hold_viol != 0) begin n_errors++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); end
    n_checks++; if (frm_cnt !== 16'd3) begin n_errors++;
      $display("FAIL bp_cnt: got frm %0d want 3", frm_cnt); end
  endtask

  task automatic test_len_drops();
    int s0, o0, p0, bad;
    bit ok;
    s0 = src_pos;
    o0 = got_data.size();
    p0 = ctrl_pops;
    run_frame(0, 1'b1, 2'd1, 0, ok);
    n_checks++; if (!ok || ctrl_pops != p0 + 1 || src_pos != s0) begin n_errors++;
      $display("FAIL len0: got pops %0d data %0d want 1 0", ctrl_pops - p0, src_pos - s0); end
    n_checks++; if (drop_cnt !== 16'd2) begin n_errors++;
      $display("FAIL len0_cnt: got drop %0d want 2", drop_cnt); end
    run_frame(1600, 1'b1, 2'd1, 0, ok);
    n_checks++; if (!ok || src_pos - s0 != 1600 || got_data.size() != o0) begin n_errors++;
      $display("FAIL len1600: got popped %0d out %0d want 1600 0", src_pos - s0,
               got_data.size() - o0); end
    run_frame(5, 1'b1, 2'd3, 0, ok);
    n_checks++; if (!ok || got_data.size() != o0) begin n_errors++;
      $display("FAIL class3: got ok %0d out %0d want 1 0", ok, got_data.size() - o0); end
    n_checks++; if (drop_cnt !== 16'd4 || frm_cnt !== 16'd3) begin n_errors++;
      $display("FAIL drops_cnt: got frm %0d drop %0d want 3 4", frm_cnt, drop_cnt); end
    s0 = src_pos;
    run_frame(1522, 1'b1, 2'd2, 1522, ok);
    bad = count_bad(o0, s0, 1522, 1);
    n_checks++; if (!ok || bad != 0 || frm_cnt !== 16'd4) begin n_errors++;
      $display("FAIL maxlen: got ok %0d bad %0d frm %0d want 1 0 4", ok, bad, frm_cnt); end
  endtask

  task automatic test_underflow();
    int s0, o0, bad;
    bit ok;
    s0 = src_pos;
    o0 = got_data.size();
    stall_at = s0 + 10;
    stall_left = 5;
    run_frame(30, 1'b1, 2'd1, 30, ok);
    bad = count_bad(o0, s0, 30, 0);
    n_checks++; if (!ok || bad != 0 || got_data.size() - o0 != 30) begin n_errors++;
      $display("FAIL underflow: got ok %0d bad %0d n %0d want 1 0 30", ok, bad,
               got_data.size() - o0); end
    n_checks++; if (stall_left != 0 || frm_cnt !== 16'd5) begin n_errors++;
      $display("FAIL underflow_cnt: got stall %0d frm %0d want 0 5", stall_left, frm_cnt); end
  endtask

  task automatic test_reset_midframe();
    int s0, o0, bad;
    bit ok;
    o0 = got_data.size();
    ctrl_len = 11'd64; ctrl_crc_ok = 1'b1; ctrl_class = 2'd1; ctrl_vld = 1'b1;
    for (int i = 0; i < 200 && got_data.size() - o0 < 20; i++) step();
    n_checks++; if (got_data.size() - o0 != 20) begin n_errors++;
      $display("FAIL mid_reach20: got %0d bytes want 20", got_data.size() - o0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_vld !== 2'b00 || out_data !== 8'h00 || out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst_out: got vld %b data %h last %b want 00 00 0", out_vld,
               out_data, out_last); end
    n_checks++; if (frm_cnt !== 16'd0 || drop_cnt !== 16'd0 || data_in_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst_state: got frm %0d drop %0d rdy %b want 0 0 0", frm_cnt,
               drop_cnt, data_in_rdy); end
    ctrl_vld = 1'b0; src_pos = 0; data_in = '0; hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = src_pos;
    o0 = got_data.size();
    run_frame(16, 1'b1, 2'd2, 16, ok);
    bad = count_bad(o0, s0, 16, 1);
    n_checks++; if (!ok || bad != 0 || frm_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL post_rst: got ok %0d bad %0d frm %0d drop %0d want 1 0 1 0", ok, bad,
               frm_cnt, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_crc_drop_then_dest2();
    test_backpressure();
    test_len_drops();
    test_underflow();
    test_reset_midframe();
    n_checks++; if (onehot_viol != 0) begin n_errors++;
      $display("FAIL onehot: got %0d multi-hot cycles want 0", onehot_viol); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
